// File: rtl/zigbee_chip_spreader.sv
// ZigBee 2.4 GHz DSSS chip spreader: PPDU bytes -> two 4-bit symbols -> 32-chip PN sequences.
// Optional raw-bit bypass per byte when SPREADER_BYPASS_EN is defined.
module zigbee_chip_spreader (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_byte_ready,
    output logic       o_data,
    output logic       o_empty,
    input  logic       i_ready,
`ifdef SPREADER_BYPASS_EN
    input  logic       i_bypass,
`endif
    output logic       o_busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Symbol 0 chips with c0 in the MSB, so chip c_i sits at bit (31 - i).
    localparam logic [31:0] SYM0_CHIPS = 32'b11011001110000110101001000101110;

    state_t      state_q,      state_d;
    logic [7:0]  active_q,     active_d;
    logic        nib_q,        nib_d;
    logic [4:0]  chipIdx_q,    chipIdx_d;
    logic [7:0]  holdByte_q,   holdByte_d;
    logic        holdValid_q,  holdValid_d;
    logic        activeByp_q,  activeByp_d;
    logic        holdByp_q,    holdByp_d;

    logic        inByp;
    logic        accept;
    logic [4:0]  lastIdx;
    logic        lastNib;
    logic [3:0]  symbol;
    logic        spreadChip;
    logic        rawChip;
    logic        chip;

`ifdef SPREADER_BYPASS_EN
    assign inByp = i_bypass;
`else
    assign inByp = 1'b0;
`endif

    // Symbols 1..7 are symbol 0 delayed by 4k chips; symbols 8..15 also flip the odd chips.
    function automatic logic romChip(input logic [3:0] sym, input logic [4:0] idx);
        logic [4:0] base;
        base    = idx - {sym[2:0], 2'b00};
        romChip = SYM0_CHIPS[~base] ^ (sym[3] & idx[0]);
    endfunction

    assign accept     = i_valid && !holdValid_q;
    assign lastIdx    = activeByp_q ? 5'd7 : 5'd31;
    assign lastNib    = activeByp_q | nib_q;
    assign symbol     = nib_q ? active_q[7:4] : active_q[3:0];
    assign spreadChip = romChip(symbol, chipIdx_q);
    assign rawChip    = active_q[chipIdx_q[2:0]];
    assign chip       = activeByp_q ? rawChip : spreadChip;

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        nib_d       = nib_q;
        chipIdx_d   = chipIdx_q;
        holdByte_d  = holdByte_q;
        holdValid_d = holdValid_q;
        activeByp_d = activeByp_q;
        holdByp_d   = holdByp_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SEND;
                    active_d    = i_byte;
                    activeByp_d = inByp;
                    nib_d       = 1'b0;
                    chipIdx_d   = 5'd0;
                end
            end
            SEND: begin
                if (accept) begin
                    holdByte_d  = i_byte;
                    holdByp_d   = inByp;
                    holdValid_d = 1'b1;
                end
                if (i_ready) begin
                    if (chipIdx_q != lastIdx) begin
                        chipIdx_d = chipIdx_q + 5'd1;
                    end else if (!lastNib) begin
                        chipIdx_d = 5'd0;
                        nib_d     = 1'b1;
                    end else begin
                        chipIdx_d = 5'd0;
                        nib_d     = 1'b0;
                        // A byte arriving on the final chip bypasses hold for a gapless stream.
                        if (holdValid_q) begin
                            active_d    = holdByte_q;
                            activeByp_d = holdByp_q;
                            holdValid_d = 1'b0;
                        end else if (accept) begin
                            active_d    = i_byte;
                            activeByp_d = inByp;
                            holdValid_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            active_q    <= 8'd0;
            nib_q       <= 1'b0;
            chipIdx_q   <= 5'd0;
            holdByte_q  <= 8'd0;
            holdValid_q <= 1'b0;
            activeByp_q <= 1'b0;
            holdByp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            nib_q       <= nib_d;
            chipIdx_q   <= chipIdx_d;
            holdByte_q  <= holdByte_d;
            holdValid_q <= holdValid_d;
            activeByp_q <= activeByp_d;
            holdByp_q   <= holdByp_d;
        end
    end

    assign o_byte_ready = !holdValid_q;
    assign o_empty      = (state_q == IDLE);
    assign o_busy       = (state_q != IDLE);
    assign o_data       = (state_q == SEND) & chip;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Directed bench for zigbee_chip_spreader: table of bytes with hand-derived chip words,
// plus sequences for back-to-back bytes, pulsed i_ready, mid-byte reset and (optionally) bypass.
module tb_zigbee_chip_spreader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_byte;
    logic       i_valid;
    logic       i_ready;
    logic       o_byte_ready;
    logic       o_data;
    logic       o_empty;
    logic       o_busy;
`ifdef SPREADER_BYPASS_EN
    logic       i_bypass;
`endif

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [7:0]  byteIn;
        logic [31:0] lowChips;
        logic [31:0] highChips;
    } vec_t;

    vec_t vecs[5];

    zigbee_chip_spreader dut (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_valid      (i_valid),
        .o_byte_ready (o_byte_ready),
        .o_data       (o_data),
        .o_empty      (o_empty),
        .i_ready      (i_ready),
`ifdef SPREADER_BYPASS_EN
        .i_bypass     (i_bypass),
`endif
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic applyStimulus(input logic [7:0] b);
        bit taken;
        taken   = 1'b0;
        i_byte  = b;
        i_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            taken = o_byte_ready;
            @(negedge clk);
            if (taken) break;
        end
        i_valid = 1'b0;
        checkOutput("byte accepted", 32'(taken), 32'd1);
    endtask

    // Samples n chips (c0 into the MSB), one per negedge; drops i_valid once a pending byte is taken.
    task automatic collectChips(input int n, output logic [31:0] w, output int gaps);
        bit taken;
        w    = '0;
        gaps = 0;
        for (int i = 0; i < n; i++) begin
            if (o_empty) gaps++;
            w[31-i] = o_data;
            taken   = i_valid && o_byte_ready;
            @(negedge clk);
            if (taken) i_valid = 1'b0;
        end
    endtask

    task automatic runVector(input vec_t v, input string name);
        logic [31:0] w;
        int          g1, g2;
        applyStimulus(v.byteIn);
        collectChips(32, w, g1);
        checkOutput({name, " low symbol"}, w, v.lowChips);
        collectChips(32, w, g2);
        checkOutput({name, " high symbol"}, w, v.highChips);
        checkOutput({name, " no gaps"}, 32'(g1 + g2), 32'd0);
        checkOutput({name, " empty after"}, 32'(o_empty), 32'd1);
        checkOutput({name, " idle after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          g, gTot, changes;

        vecs[0] = '{8'h00, 32'b11011001110000110101001000101110, 32'b11011001110000110101001000101110};
        vecs[1] = '{8'hA1, 32'b11101101100111000011010100100010, 32'b01111011100011001001011000000111};
        vecs[2] = '{8'h3C, 32'b00000111011110111000110010010110, 32'b00100010111011011001110000110101};
        vecs[3] = '{8'h55, 32'b00110101001000101110110110011100, 32'b00110101001000101110110110011100};
        vecs[4] = '{8'h40, 32'b11011001110000110101001000101110, 32'b01010010001011101101100111000011};

        reset   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_byte  = 8'h00;
`ifdef SPREADER_BYPASS_EN
        i_bypass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset empty", 32'(o_empty), 32'd1);
        checkOutput("reset data", 32'(o_data), 32'd0);
        checkOutput("reset byte_ready", 32'(o_byte_ready), 32'd1);
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            runVector(vecs[k], $sformatf("vec%0d", k));
        end

        // 0x3C then 0x55 back to back with continuous i_ready.
        applyStimulus(8'h3C);
        i_byte  = 8'h55;
        i_valid = 1'b1;
        collectChips(32, w, g);
        gTot = g;
        checkOutput("b2b 3C low", w, vecs[2].lowChips);
        checkOutput("b2b hold full", 32'(o_byte_ready), 32'd0);
        collectChips(32, w, g);
        gTot += g;
        checkOutput("b2b 3C high", w, vecs[2].highChips);
        collectChips(32, w, g);
        gTot += g;
        checkOutput("b2b 55 low", w, vecs[3].lowChips);
        collectChips(32, w, g);
        gTot += g;
        checkOutput("b2b 55 high", w, vecs[3].highChips);
        checkOutput("b2b no gaps", 32'(gTot), 32'd0);
        checkOutput("b2b empty after", 32'(o_empty), 32'd1);

        // Byte offered exactly on the final chip with hold empty.
        applyStimulus(8'h00);
        collectChips(32, w, g);
        gTot = g;
        collectChips(31, w, g);
        gTot += g;
        i_byte  = 8'h55;
        i_valid = 1'b1;
        collectChips(1, w, g);
        gTot += g;
        checkOutput("last-chip accept not empty", 32'(o_empty), 32'd0);
        collectChips(32, w, g);
        gTot += g;
        checkOutput("last-chip 55 low", w, vecs[3].lowChips);
        collectChips(32, w, g);
        gTot += g;
        checkOutput("last-chip 55 high", w, vecs[3].highChips);
        checkOutput("last-chip no gaps", 32'(gTot), 32'd0);
        checkOutput("last-chip empty after", 32'(o_empty), 32'd1);

        // i_ready pulsed once every 25 cycles.
        i_ready = 1'b0;
        applyStimulus(8'hA1);
        for (int p = 0; p < 4; p++) begin
            changes = 0;
            for (int c = 0; c < 24; c++) begin
                if (o_data !== vecs[1].lowChips[31-p] || o_empty) changes++;
                @(negedge clk);
            end
            checkOutput($sformatf("pulse hold chip %0d", p), 32'(changes), 32'd0);
            i_ready = 1'b1;
            @(negedge clk);
            i_ready = 1'b0;
        end
        checkOutput("pulse advanced to chip 4", 32'(o_data), 32'(vecs[1].lowChips[27]));
        i_ready = 1'b1;
        for (int t = 0; t < 100 && !o_empty; t++) @(negedge clk);
        checkOutput("pulse drain finished", 32'(o_empty), 32'd1);

        // i_ready activity in IDLE must not disturb anything.
        changes = 0;
        for (int c = 0; c < 10; c++) begin
            i_ready = c[0];
            @(negedge clk);
            if (!o_empty || o_busy || !o_byte_ready || o_data) changes++;
        end
        checkOutput("idle ready ignored", 32'(changes), 32'd0);
        i_ready = 1'b1;
        runVector(vecs[1], "after idle ready");

        // Reset at chip 17 of the high nibble with a byte waiting in hold.
        applyStimulus(8'hA1);
        i_byte  = 8'h55;
        i_valid = 1'b1;
        collectChips(32, w, g);
        collectChips(17, w, g);
        checkOutput("pre-reset hold full", 32'(o_byte_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mid reset empty", 32'(o_empty), 32'd1);
        checkOutput("mid reset data", 32'(o_data), 32'd0);
        checkOutput("mid reset byte_ready", 32'(o_byte_ready), 32'd1);
        checkOutput("mid reset busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runVector(vecs[1], "after reset");

`ifdef SPREADER_BYPASS_EN
        i_bypass = 1'b1;
        applyStimulus(8'hB2);
        i_bypass = 1'b0;
        collectChips(8, w, g);
        checkOutput("bypass B2 bits", w, {8'b01001101, 24'd0});
        checkOutput("bypass no gaps", 32'(g), 32'd0);
        checkOutput("bypass empty after", 32'(o_empty), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
